// File: rtl/fifo_wr_pkg.sv
// Shared types and constants for the FIFO write-side feeder.
package fifo_wr_pkg;

  // Packet-tracking FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DONE = 2'd2
  } wr_state_e;

  // Default packet-length counter width.
  localparam int LW_DEFAULT = 8;

  // Saturation value of the stall-cycle counter.
  localparam logic [15:0] STALL_SAT = 16'hFFFF;

endpackage

// File: rtl/fifo_wr_skid.sv
// Two-entry skid buffer with valid/ready on both sides.
// Entry0 is the head presented downstream; entry1 catches the word accepted
// while the head is stalled. in_ready_o is the inverse of the entry1 valid
// flop, so the producer side sees no combinational path from out_ready_i.
module fifo_wr_skid #(
  parameter int W = 9
) (
  input  logic         wclk,
  input  logic         dir_clr_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         e0_v_q, e0_v_d;
  logic         e1_v_q, e1_v_d;
  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic         push, pop;

  assign in_ready_o  = ~e1_v_q;
  assign out_valid_o = e0_v_q;
  assign out_data_o  = e0_q;

  assign push = in_valid_i & ~e1_v_q;
  assign pop  = e0_v_q & out_ready_i;

  // Next-state for the two entries: advance on pop, fill the first free slot on push.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    e0_v_d = e0_v_q;
    e1_v_d = e1_v_q;
    e0_d   = e0_q;
    e1_d   = e1_q;
    if (pop) begin
      if (e1_v_q) begin
        // Entry1 full means in_ready_o was low, so no push can coincide.
        e0_d   = e1_q;
        e1_v_d = 1'b0;
      end else if (push) begin
        e0_d = in_data_i;
      end else begin
        e0_v_d = 1'b0;
      end
    end else if (push) begin
      if (e0_v_q) begin
        e1_d   = in_data_i;
        e1_v_d = 1'b1;
      end else begin
        e0_d   = in_data_i;
        e0_v_d = 1'b1;
      end
    end
  end

  // Entry registers.
  always_ff @(posedge wclk or negedge dir_clr_n) begin
    if (!dir_clr_n) begin
      // NOTE: the data entries are reset too; there are only two, and the head drives wdata, which must read zero out of reset.
      e0_v_q <= 1'b0;
      e1_v_q <= 1'b0;
      e0_q   <= '0;
      e1_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      e0_v_q <= e0_v_d;
      e1_v_q <= e1_v_d;
      e0_q   <= e0_d;
      e1_q   <= e1_d;
    end
  end

endmodule

// File: rtl/fifo_wr_stage.sv
// Write-side feeder for the asynchronous FIFO (wclk domain).
// Buffers the producer stream in a two-entry skid buffer, writes the FIFO
// only while wfull is low, and reports per-packet word counts.
// Optional build macro WR_STATS_EN adds word_cnt and stall_cnt outputs.
module fifo_wr_stage
  import fifo_wr_pkg::*;
#(
  parameter int DW = 8,
  parameter int LW = LW_DEFAULT
) (
  input  logic          wclk,
  input  logic          dir_clr_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  input  logic          wfull,
  output logic          wr,
  output logic [DW-1:0] wdata,
  output logic          pkt_done,
  output logic [LW-1:0] pkt_len,
  output logic          pkt_ovf,
`ifdef WR_STATS_EN
  output logic [31:0]   word_cnt,
  output logic [15:0]   stall_cnt,
`endif
  output logic          busy
);

  localparam logic [LW-1:0] LEN_MAX = '1;

  wr_state_e     state_q, state_d;
  logic [LW-1:0] len_q, len_d, len_next;
  logic          ovf_q, ovf_d, ovf_next;
  logic [LW-1:0] pkt_len_q, pkt_len_d;
  logic          pkt_ovf_q, pkt_ovf_d;
  logic          head_valid;
  logic [DW:0]   head_data;
  logic          head_last;

  fifo_wr_skid #(.W(DW + 1)) u_skid (
    .wclk        (wclk),
    .dir_clr_n   (dir_clr_n),
    .in_valid_i  (s_valid),
    .in_ready_o  (s_ready),
    .in_data_i   ({s_last, s_data}),
    .out_valid_o (head_valid),
    .out_ready_i (~wfull),
    .out_data_o  (head_data)
  );

  // The head is written whenever it is valid and the FIFO has room; wfull acts within the cycle.
  assign wr        = head_valid & ~wfull;
  assign wdata     = head_data[DW-1:0];
  assign head_last = head_data[DW];

  assign pkt_done = (state_q == DONE);
  assign pkt_len  = pkt_len_q;
  assign pkt_ovf  = pkt_ovf_q;
  assign busy     = (state_q != IDLE) | head_valid;

  // Packet FSM and length counting; the report registers load on the write of the last word.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    pkt_len_d = pkt_len_q;
    pkt_ovf_d = pkt_ovf_q;
    // Count including the word written this cycle; IDLE and DONE start a fresh packet.
    if (state_q == PKT) begin
      len_next = (len_q == LEN_MAX) ? len_q : len_q + 1'b1;
      ovf_next = ovf_q | (len_q == LEN_MAX);
    end else begin
      len_next = LW'(1);
      ovf_next = 1'b0;
    end
    if (wr) begin
      len_d = len_next;
      ovf_d = ovf_next;
      if (head_last) begin
        state_d   = DONE;
        pkt_len_d = len_next;
        pkt_ovf_d = ovf_next;
      end else begin
        state_d = PKT;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  // FSM and counter registers.
  always_ff @(posedge wclk or negedge dir_clr_n) begin
    if (!dir_clr_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      pkt_len_q <= '0;
      pkt_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      pkt_len_q <= pkt_len_d;
      pkt_ovf_q <= pkt_ovf_d;
    end
  end

`ifdef WR_STATS_EN
  logic [31:0] word_cnt_q;
  logic [15:0] stall_cnt_q;

  assign word_cnt  = word_cnt_q;
  assign stall_cnt = stall_cnt_q;

  // Wrapping count of FIFO writes and saturating count of stalled cycles.
  always_ff @(posedge wclk or negedge dir_clr_n) begin
    if (!dir_clr_n) begin
      word_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (wr) begin
        word_cnt_q <= word_cnt_q + 32'd1;
      end
      if (head_valid && wfull && (stall_cnt_q != STALL_SAT)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_stage.sv
// Scoreboard bench for fifo_wr_stage: the driver pushes expected FIFO words
// and packet reports into queues; a negedge monitor pops and compares
// whenever wr or pkt_done is presented.
module tb_fifo_wr_stage;

  typedef struct packed {
    logic [7:0] len;
    logic       ovf;
  } pkt_t;

  logic       wclk;
  logic       dir_clr_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       wfull;
  logic       wr;
  logic [7:0] wdata;
  logic       pkt_done;
  logic [7:0] pkt_len;
  logic       pkt_ovf;
  logic       busy;
`ifdef WR_STATS_EN
  logic [31:0] word_cnt;
  logic [15:0] stall_cnt;
`endif

  fifo_wr_stage #(.DW(8), .LW(8)) dut (
    .wclk      (wclk),
    .dir_clr_n (dir_clr_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .wfull     (wfull),
    .wr        (wr),
    .wdata     (wdata),
    .pkt_done  (pkt_done),
    .pkt_len   (pkt_len),
    .pkt_ovf   (pkt_ovf),
`ifdef WR_STATS_EN
    .word_cnt  (word_cnt),
    .stall_cnt (stall_cnt),
`endif
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int writes_seen = 0;
  int exp_words = 0;
  int cur_cnt = 0;
  int first_acc = 0;
  int last_acc = 0;
  bit done_flag = 0;

  logic [7:0] wq[$];
  pkt_t       pq[$];
  int         wr_cyc[$];
  int         done_cyc[$];
  logic [7:0] mon_e;
  pkt_t       mon_p;

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  always @(posedge wclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every FIFO write and every packet report against the queues.
  always @(negedge wclk) begin
    if (dir_clr_n) begin
      if (wr) begin
        wr_cyc.push_back(cyc);
        writes_seen++;
        check("write_expected", 32'(wq.size() > 0), 32'd1);
        if (wq.size() > 0) begin
          mon_e = wq.pop_front();
          check("wdata", 32'(wdata), 32'(mon_e));
        end
      end
      if (pkt_done) begin
        done_cyc.push_back(cyc);
        check("pkt_expected", 32'(pq.size() > 0), 32'd1);
        if (pq.size() > 0) begin
          mon_p = pq.pop_front();
          check("pkt_len", 32'(pkt_len), 32'(mon_p.len));
          check("pkt_ovf", 32'(pkt_ovf), 32'(mon_p.ovf));
        end
      end
    end
  end

  // Issue one word; record the expected write and, on last, the expected report.
  task automatic send(input logic [7:0] d, input logic l);
    int   guard;
    logic rdy;
    wq.push_back(d);
    exp_words++;
    cur_cnt++;
    if (l) begin
      pq.push_back('{len: (cur_cnt > 255) ? 8'd255 : 8'(cur_cnt), ovf: (cur_cnt > 255)});
      cur_cnt = 0;
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    guard   = 0;
    forever begin
      @(negedge wclk);
      rdy = s_ready;
      @(posedge wclk);
      if (rdy) break;
      guard++;
      if (guard >= 2000) begin
        check("accept_in_time", 32'(rdy), 32'd1);
        break;
      end
    end
    #1;
    last_acc = cyc;
    s_valid  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((wq.size() != 0 || pq.size() != 0) && n < 5000) begin
      @(posedge wclk);
      n++;
    end
    check("drain_in_time", 32'(wq.size() == 0 && pq.size() == 0), 32'd1);
    repeat (2) @(posedge wclk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    check({tag, "_wr"}, 32'(wr), 32'd0);
    check({tag, "_wdata"}, 32'(wdata), 32'd0);
    check({tag, "_pkt_done"}, 32'(pkt_done), 32'd0);
    check({tag, "_pkt_len"}, 32'(pkt_len), 32'd0);
    check({tag, "_pkt_ovf"}, 32'(pkt_ovf), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef WR_STATS_EN
    check({tag, "_word_cnt"}, word_cnt, 32'd0);
    check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    dir_clr_n = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    wfull     = 1'b0;
    #1;
    check_reset_outputs("reset");
    #21;
    dir_clr_n = 1'b1;
    @(posedge wclk);
    #1;

    // 4-word packet with the FIFO never full.
    wr_cyc.delete();
    done_cyc.delete();
    send(8'h11, 1'b0);
    first_acc = last_acc;
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    wait_drain();
    check("p4_write_count", 32'(wr_cyc.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wr_cyc.size()) check("p4_write_cycle", 32'(wr_cyc[i]), 32'(first_acc + i));
    end
    check("p4_done_count", 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() > 0) check("p4_done_cycle", 32'(done_cyc[0]), 32'(first_acc + 4));

    // Five-cycle wfull stall in the middle of a 6-word packet.
    begin
      int base;
      base = writes_seen;
      fork
        begin
          for (int i = 0; i < 6; i++) send(8'h50 + 8'(i), i == 5);
        end
        begin
          int n;
          n = 0;
          while (writes_seen < base + 2 && n < 100) begin
            @(posedge wclk);
            #1;
            n++;
          end
          wfull = 1'b1;
          repeat (5) begin
            @(negedge wclk);
            check("stall_wr", 32'(wr), 32'd0);
            check("stall_wdata", 32'(wdata), 32'(wq[0]));
          end
          check("stall_s_ready", 32'(s_ready), 32'd0);
          @(posedge wclk);
          #1;
          wfull = 1'b0;
        end
      join
    end
    wait_drain();
`ifdef WR_STATS_EN
    check("stall_cnt", 32'(stall_cnt), 32'd5);
`endif

    // Back-to-back single-word packets.
    done_cyc.delete();
    send(8'hA0, 1'b1);
    send(8'hA1, 1'b1);
    wait_drain();
    check("single_done_count", 32'(done_cyc.size()), 32'd2);
    if (done_cyc.size() == 2) check("single_done_gap", 32'(done_cyc[1] - done_cyc[0]), 32'd1);

    // Length boundary: exactly 2^LW-1 words, then an overflowing 300-word packet.
    for (int i = 0; i < 255; i++) send(8'(i), i == 254);
    for (int i = 0; i < 300; i++) send(8'(i + 7), i == 299);
    wait_drain();

    // Reset in the middle of a 5-word packet, with one word still buffered.
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    wait_drain();
    wfull = 1'b1;
    send(8'h63, 1'b0);
    @(negedge wclk);
    #2;
    dir_clr_n = 1'b0;
    #1;
    void'(wq.pop_back());
    exp_words = 0;
    cur_cnt   = 0;
    check_reset_outputs("mid_reset");
    @(posedge wclk);
    #1;
    dir_clr_n = 1'b1;
    wfull     = 1'b0;
    repeat (4) @(posedge wclk);
    #1;
    check("post_reset_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) send(8'h70 + 8'(i), i == 4);
    wait_drain();

    // Random producer gaps and wfull toggling over 10000 words.
    done_flag = 1'b0;
    fork
      begin
        int left;
        int plen;
        left = 10000;
        while (left > 0) begin
          plen = int'($urandom_range(1, 20));
          if (plen > left) plen = left;
          for (int j = 0; j < plen; j++) begin
            if ($urandom_range(0, 3) == 0) begin
              repeat (int'($urandom_range(1, 3))) @(posedge wclk);
              #1;
            end
            send(8'($urandom_range(0, 255)), j == plen - 1);
          end
          left -= plen;
        end
        done_flag = 1'b1;
      end
      begin
        while (!done_flag) begin
          @(posedge wclk);
          #1;
          wfull = ($urandom_range(0, 3) == 0);
        end
        wfull = 1'b0;
      end
    join
    wait_drain();
`ifdef WR_STATS_EN
    check("word_cnt", word_cnt, 32'(exp_words));
`endif
    check("final_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
